// File: rtl/sync_launch.sv
// -----------------------------------------------------------------------------
// sync_launch
//
// Source-domain launcher for a two-flop strobe synchronizer. A word is taken
// through a valid/ready handshake, registered onto data_out, and announced
// with a strobe held high for STB_LEN enabled cycles. The word then stays
// quiet for HOLD_LEN more enabled cycles before the next word can be taken,
// so the receiving side always captures stable data.
//
// Parameters
//   N        data width in bits
//   STB_LEN  strobe high time in clk cycles (1..255)
//   HOLD_LEN guard time after the strobe falls, in clk cycles (1..255)
//
// Ports
//   clk       in   transmitting-domain clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   design enable; low freezes every register
//   in_data   in   word to launch
//   in_valid  in   in_data is valid
//   in_ready  out  block can accept (ena and idle)
//   data_out  out  registered launched word
//   stb_out   out  registered strobe, driven straight from a flop
//   busy      out  registered, high while not idle
//   tx_count  out  registered count of accepted words, wraps at 256
// -----------------------------------------------------------------------------
module sync_launch #(
    parameter int N        = 8,
    parameter int STB_LEN  = 4,
    parameter int HOLD_LEN = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] data_out,
    output logic         stb_out,
    output logic         busy,
    output logic [7:0]   tx_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Counter reload values: the phase ends on the cycle the counter reads 0.
    localparam logic [7:0] STB_RELOAD  = 8'(STB_LEN - 1);
    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_LEN - 1);

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [N-1:0]   data_q, data_d;
    logic           stb_q, stb_d;
    logic           busy_q, busy_d;
    logic [7:0]     tx_q, tx_d;
    logic           accept_s;

    assign accept_s = ena & in_valid & (state_q == IDLE);

    // State and datapath registers; every _d already holds its value when ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            data_q  <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            tx_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state and phase down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!ena) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = PULSE;
                        cnt_d   = STB_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PULSE: begin
                    if (cnt_q == 8'd0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_RELOAD;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Output next values: capture on accept, drop the strobe when PULSE ends.
    always_comb begin
        data_d = data_q;
        stb_d  = stb_q;
        tx_d   = tx_q;
        busy_d = (state_d != IDLE);
        if (accept_s) begin
            data_d = in_data;
            stb_d  = 1'b1;
            tx_d   = tx_q + 8'd1;
        end else if (ena && (state_q == PULSE) && (cnt_q == 8'd0)) begin
            stb_d  = 1'b0;
        end else if (state_q != PULSE) begin
            // Outside PULSE the strobe is always low; also recovers an illegal state.
            stb_d  = 1'b0;
        end else begin
            stb_d  = stb_q;
        end
    end

    assign in_ready = ena & (state_q == IDLE);
    assign data_out = data_q;
    assign stb_out  = stb_q;
    assign busy     = busy_q;
    assign tx_count = tx_q;

endmodule

// File: doc/sync_launch.md
# sync_launch

Source-domain launcher that feeds the two-flop strobe synchronizer. It runs on the transmitting clock and accepts words through a valid/ready handshake. It registers each word and drives a strobe pulse stretched to `STB_LEN` cycles so the slower or unrelated receiving clock is guaranteed to sample it. It then holds the data stable for a further `HOLD_LEN` cycles before accepting the next word, so the synchronizer's capture register always sees quiet data.

## Interface
- `N`, 8, data width in bits.
- `STB_LEN`, 4, strobe high time in clk cycles; legal range 1..255.
- `HOLD_LEN`, 8, guard time in clk cycles after strobe falls, data held and strobe low; legal range 1..255.

- `clk`  in  1  transmitting-domain clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; assertion clears state immediately, release is synchronous to `clk` by the system.
- `ena`  in  1  design enable; low freezes every register.
- `in_data`  in  N  word to launch.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept; equal to `ena & (state==IDLE)`, combinational from registered state.
- `data_out`  out  N  registered launched word, to the synchronizer `data_in`.
- `stb_out`  out  1  registered strobe, to the synchronizer `stb`.
- `busy`  out  1  registered, high whenever state != IDLE.
- `tx_count`  out  8  registered count of accepted words; wraps 255->0.

## Operation
- Reset values: `data_out`=0, `stb_out`=0, `busy`=0, `tx_count`=0, state=IDLE, down-counter `cnt`=0; `in_ready` therefore equals `ena`.
- Accept occurs on any rising edge with `ena & in_valid & in_ready`.
- States and transitions, all gated by `ena`:
  - IDLE, on accept: `data_out`<=`in_data`, `stb_out`<=1, `cnt`<=STB_LEN-1, `tx_count`<=`tx_count`+1 mod 256, go to PULSE.
  - PULSE, if `cnt`==0: `stb_out`<=0, `cnt`<=HOLD_LEN-1, go to HOLD; else `cnt`<=`cnt`-1.
  - HOLD, if `cnt`==0: go to IDLE; else `cnt`<=`cnt`-1.
- `cnt` is 8 bits wide and never wraps in legal configurations.
- `data_out` changes only on accept. It is stable through PULSE and HOLD, and from then until the next accept.
- `in_valid` without `in_ready` has no effect. No data is lost; the source must wait.
- `ena` low: all registers hold their values, including mid-PULSE (`stb_out` stays high, pulse is extended) and mid-HOLD. `in_ready`=0.
- `rst_n` asserted mid-operation: `stb_out` drops to 0 asynchronously, the in-flight word is abandoned, and `data_out` clears to 0.

## Timing
- Accept at edge k: `data_out` and `stb_out`=1 are visible after edge k. `busy` rises at edge k.
- `stb_out` is high for exactly STB_LEN consecutive enabled cycles and falls after edge k+STB_LEN.
- State returns to IDLE after edge k+STB_LEN+HOLD_LEN. `in_ready` is high in the following cycle.
- Minimum accept-to-accept spacing is STB_LEN+HOLD_LEN+1 enabled cycles. A back-to-back `in_valid` is taken at the first cycle `in_ready` is high.
- `stb_out` is glitch-free; it is driven directly from a flop.
- The integrator sizes STB_LEN so that the pulse covers at least 2 receiving-clock periods. The block does not check this.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with `ena`=1. Required: all outputs 0, `in_ready`=1; no `stb_out` activity without `in_valid`.
- Single word, default parameters: `in_data`=8'hA5 with `in_valid` for 1 cycle. Required: `data_out`=A5 and `stb_out` high for exactly 4 cycles, then low. `in_ready` returns 13 cycles after accept, `tx_count`=1, `data_out` still A5.
- Back-to-back: `in_valid` held high with data 8'h11 then 8'h22. Required: accepts exactly 13 cycles apart, two separate 4-cycle strobes, `tx_count`=2, no word skipped or duplicated.
- Enable freeze: drop `ena` for 5 cycles at the 2nd strobe cycle. Required: `stb_out` stays high throughout and total high time is 4+5=9 clk cycles. Registers are unchanged while frozen and `in_ready`=0.
- Reset mid-operation: assert `rst_n`=0 in HOLD. Required: immediate `stb_out`=0, `data_out`=0, `busy`=0, `tx_count`=0. A new word is accepted in the first cycle after release.
- Wrap and edge parameters: with STB_LEN=1 and HOLD_LEN=1, send 257 words. Required: `tx_count`=1, each strobe exactly 1 cycle, and accept spacing of 3 cycles.
